// File: rtl/canakari_tx_writer_if.sv
// Frame handshake and CANakari register-port signals for canakari_tx_writer.
// master = frame source / controller side, slave = the writer block.
interface canakari_tx_writer_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [10:0] frame_id;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic [4:0]  addr_out;
  logic        buffer_en;
  logic [15:0] wdata_out;
  logic        wr_strobe;
  logic        tx_done;

  modport master (
    output frame_valid, frame_id, frame_dlc, frame_data, tx_done,
    input  frame_ready, addr_out, buffer_en, wdata_out, wr_strobe
  );

  modport slave (
    input  frame_valid, frame_id, frame_dlc, frame_data, tx_done,
    output frame_ready, addr_out, buffer_en, wdata_out, wr_strobe
  );
endinterface

// File: rtl/canakari_tx_writer.sv
// Breaks one CAN frame into ID / data / control register writes for CANakari.
// Optional WAIT_ACK timeout is enabled by defining CANAKARI_TX_TIMEOUT_EN.
module canakari_tx_writer #(
  parameter logic [4:0]  ADDR_TXID    = 5'h0E,
  parameter logic [4:0]  ADDR_TXDATA0 = 5'h0F,
  parameter logic [4:0]  ADDR_TXCTRL  = 5'h13
`ifdef CANAKARI_TX_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT      = 16'd50000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  canakari_tx_writer_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_ACK,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [2:0]  k_q;
  logic [2:0]  n_q;
  logic [10:0] id_q;
  logic [3:0]  len_q;
  logic [63:0] data_q;

  logic        accept;
  logic        last_write;
  logic [3:0]  len_c;
  logic [2:0]  n_c;
  logic [4:0]  addr_c;
  logic [15:0] wdata_c;

  assign accept     = (state == IDLE) && bus.frame_valid;
  assign last_write = (k_q == n_q + 3'd1);
  assign len_c      = (bus.frame_dlc > 4'd8) ? 4'd8 : bus.frame_dlc;
  assign n_c        = 3'((len_c + 4'd1) >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      n_q    <= '0;
      id_q   <= '0;
      len_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      k_q    <= '0;
      n_q    <= n_c;
      id_q   <= bus.frame_id;
      len_q  <= len_c;
      data_q <= bus.frame_data;
    end else if (state == STROBE && !last_write) begin
      k_q <= k_q + 3'd1;
    end
  end

  // Write entry k: 0 = ID, 1..N = data words, N+1 = control with TX request.
  always_comb begin
    addr_c  = '0;
    wdata_c = '0;
    if (k_q == 3'd0) begin
      addr_c  = ADDR_TXID;
      wdata_c = {id_q, 5'b00000};
    end else if (k_q <= n_q) begin
      addr_c = ADDR_TXDATA0 + {2'b00, k_q} - 5'd1;
      case (k_q)
        3'd1:    wdata_c = data_q[63:48];
        3'd2:    wdata_c = data_q[47:32];
        3'd3:    wdata_c = data_q[31:16];
        default: wdata_c = data_q[15:0];
      endcase
    end else begin
      addr_c  = ADDR_TXCTRL;
      wdata_c = {11'b0, 1'b1, len_q};
    end
  end

`ifdef CANAKARI_TX_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        expire;
  logic        timeout_q;

  // Counter is held at zero outside WAIT_ACK, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_ACK) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign expire = (state == WAIT_ACK) && !bus.tx_done &&
                  (wait_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (accept) state_n = SETUP;
      SETUP:    state_n = STROBE;
      STROBE:   state_n = last_write ? WAIT_ACK : SETUP;
      WAIT_ACK: begin
        if (bus.tx_done) begin
          state_n = FINISH;
        end
`ifdef CANAKARI_TX_TIMEOUT_EN
        else if (expire) begin
          state_n = IDLE;
        end
`endif
      end
      FINISH:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign bus.frame_ready = (state == IDLE);
  assign bus.buffer_en   = (state == SETUP);
  assign bus.wr_strobe   = (state == STROBE);
  assign bus.addr_out    = (state == SETUP || state == STROBE) ? addr_c  : '0;
  assign bus.wdata_out   = (state == SETUP || state == STROBE) ? wdata_c : '0;
  assign busy            = (state != IDLE);
  assign done            = (state == FINISH);

endmodule
